// File: rtl/comma_pkg.sv
// Shared symbol width, comma pattern and FSM encoding for the comma-framed serial link.
package comma_pkg;
  localparam int SYM_W = 10;
  typedef logic [SYM_W-1:0] sym_t;
  localparam sym_t COMMA_SYM = 10'b1010001110;
  localparam logic [0:0] ST_ALIGN = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
endpackage

// File: rtl/comma_tx_serializer_if.sv
// Symbol handshake into the serializer; source holds sym_in/sym_valid until sym_ready.
interface comma_tx_serializer_if;
  import comma_pkg::*;
  sym_t sym_in;
  logic sym_valid;
  logic sym_ready;

  modport master (output sym_in, output sym_valid, input sym_ready);
  modport slave  (input sym_in, input sym_valid, output sym_ready);
endinterface

// File: rtl/comma_tx_shifter.sv
// Shift register + bit counter: MSB out each clock, reload on bit_cnt==9 (boundary).
// Latency: a loaded word's bit 9 appears on ser_o the cycle after the boundary; no backpressure.
module comma_tx_shifter
  import comma_pkg::*;
#(
  parameter sym_t COMMA = COMMA_SYM
) (
  input  logic clk,
  input  logic rst,
  input  sym_t load_dat_i,
  output logic ser_o,
  output logic start_o,
  output logic boundary_o
);
  localparam logic [3:0] LAST_BIT = 4'(SYM_W - 1);

  sym_t       shreg_q, shreg_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;

  assign boundary_o = (bit_cnt_q == LAST_BIT);
  assign start_o    = (bit_cnt_q == 4'd0);
  assign ser_o      = shreg_q[SYM_W-1];

  always_comb begin
    shreg_d   = {shreg_q[SYM_W-2:0], 1'b0};
    bit_cnt_d = bit_cnt_q + 4'd1;
    if (boundary_o) begin
      shreg_d   = load_dat_i;
      bit_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= COMMA;
      bit_cnt_q <= 4'd0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/comma_tx_serializer.sv
// Comma-framed 10b serializer: ALIGN_COUNT-comma burst after reset, commas fill idle slots; accept -> bit 9 out next cycle.
// sym_ready only on boundaries once aligned; COMMA_TX_PERIODIC_EN forces a comma after PERIOD back-to-back data symbols.
module comma_tx_serializer
  import comma_pkg::*;
#(
  parameter sym_t COMMA       = COMMA_SYM,
  parameter int   ALIGN_COUNT = 4,
  parameter int   PERIOD      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  comma_tx_serializer_if.slave        sym_if,
  output logic                        ser_out,
  output logic                        sym_start,
  output logic                        comma_load,
  output logic                        aligned
);
  localparam int AW = $clog2(ALIGN_COUNT + 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_COUNT - 1);

  if (ALIGN_COUNT < 1 || PERIOD < 2) begin : g_bad_cfg
    $error("comma_tx_serializer: ALIGN_COUNT must be >= 1 and PERIOD >= 2");
  end

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] align_cnt_q, align_cnt_d;
  logic          boundary;
  logic          slot_open;
  logic          accept;
  sym_t          load_dat;

  // The final alignment boundary already offers a data slot, so exactly ALIGN_COUNT commas lead.
  assign slot_open = boundary & ((state_q == ST_RUN) | (align_cnt_q == ALIGN_LAST));

`ifdef COMMA_TX_PERIODIC_EN
  localparam int PW = $clog2(PERIOD + 1);
  localparam logic [PW-1:0] PER_MAX = PW'(PERIOD);

  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic          force_comma;

  assign force_comma      = (per_cnt_q == PER_MAX);
  assign sym_if.sym_ready = slot_open & ~force_comma;

  always_comb begin
    per_cnt_d = per_cnt_q;
    if (boundary) begin
      per_cnt_d = accept ? per_cnt_q + PW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end
`else
  assign sym_if.sym_ready = slot_open;
`endif

  assign accept     = sym_if.sym_valid & sym_if.sym_ready;
  assign load_dat   = accept ? sym_if.sym_in : COMMA;
  assign comma_load = boundary & (state_q == ST_RUN) & ~accept;
  assign aligned    = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    if (boundary && state_q == ST_ALIGN) begin
      align_cnt_d = align_cnt_q + AW'(1);
      if (align_cnt_q == ALIGN_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ALIGN;
      align_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
    end
  end

  comma_tx_shifter #(
    .COMMA (COMMA)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_dat_i (load_dat),
    .ser_o      (ser_out),
    .start_o    (sym_start),
    .boundary_o (boundary)
  );
endmodule

// File: tb/tb_comma_tx_serializer.sv
// Bench for comma_tx_serializer: slot-level model checked every cycle plus directed literal checks.
module tb_comma_tx_serializer;
  import comma_pkg::*;

  localparam int ALIGN_COUNT = 4;
  localparam int PERIOD      = 16;
`ifdef COMMA_TX_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_out, sym_start, comma_load, aligned;

  comma_tx_serializer_if sym_if ();

  comma_tx_serializer #(
    .COMMA       (COMMA_SYM),
    .ALIGN_COUNT (ALIGN_COUNT),
    .PERIOD      (PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_if     (sym_if),
    .ser_out    (ser_out),
    .sym_start  (sym_start),
    .comma_load (comma_load),
    .aligned    (aligned)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model state: cycle index since reset release, the symbol on the wire, data run length.
  int   m_cyc, m_run, pos, slot;
  sym_t m_cur;
  logic e_rdy, e_acc, e_cl;
  int   cl_cycs[$];
  int   acc_q[$];
  int   det_q[$];
  sym_t rx_q[$];
  sym_t rx_sh, win, first_bits;
  int   rx_n, first_rdy, first_al;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ser_out", ser_out, 1);
      chk("rst_sym_start", sym_start, 1);
      chk("rst_sym_ready", sym_if.sym_ready, 0);
      chk("rst_comma_load", comma_load, 0);
      chk("rst_aligned", aligned, 0);
      m_cyc = 0; m_run = 0; m_cur = COMMA_SYM;
      cl_cycs.delete(); acc_q.delete(); det_q.delete(); rx_q.delete();
      rx_sh = '0; win = '0; first_bits = '0; rx_n = 0;
      first_rdy = -1; first_al = -1;
    end else begin
      pos   = m_cyc % 10;
      slot  = m_cyc / 10;
      e_rdy = (pos == 9) && (slot >= ALIGN_COUNT - 1) && !(PERIODIC && m_run == PERIOD);
      e_acc = e_rdy && sym_if.sym_valid;
      e_cl  = (pos == 9) && (slot >= ALIGN_COUNT) && !e_acc;
      chk($sformatf("ser_out@%0d", m_cyc), ser_out, m_cur[9-pos]);
      chk($sformatf("sym_start@%0d", m_cyc), sym_start, pos == 0);
      chk($sformatf("sym_ready@%0d", m_cyc), sym_if.sym_ready, e_rdy);
      chk($sformatf("comma_load@%0d", m_cyc), comma_load, e_cl);
      chk($sformatf("aligned@%0d", m_cyc), aligned, slot >= ALIGN_COUNT);
      if (sym_if.sym_ready && first_rdy < 0) first_rdy = m_cyc;
      if (aligned && first_al < 0) first_al = m_cyc;
      if (comma_load) cl_cycs.push_back(m_cyc);
      if (m_cyc < 10) first_bits[9-m_cyc] = ser_out;
      if (sym_start) rx_n = 0;
      rx_sh = {rx_sh[8:0], ser_out};
      rx_n++;
      if (rx_n == 10) rx_q.push_back(rx_sh);
      win = {win[8:0], ser_out};
      if (win == COMMA_SYM) det_q.push_back(m_cyc);
      if (pos == 9) begin
        if (e_acc) begin
          m_cur = sym_if.sym_in;
          m_run++;
          acc_q.push_back(m_cyc);
        end else begin
          m_cur = COMMA_SYM;
          m_run = 0;
        end
      end
      m_cyc++;
    end
  end

  // Called at posedge+1; holds the symbol until the model records its accept.
  task automatic send(input sym_t s, output int acc_at);
    int n0;
    n0 = acc_q.size();
    acc_at = -1;
    sym_if.sym_in = s;
    sym_if.sym_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (acc_q.size() > n0) begin
        acc_at = acc_q[$];
        break;
      end
    end
    sym_if.sym_valid = 1'b0;
    if (acc_at < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   a1, a2, raise, t, hit, maxrun, run, ncomma;
    int   acc5[20];
    sym_t cur;
    sym_if.sym_in = '0;
    sym_if.sym_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle alignment
    idle(60);
    chk("t1_first_ready", first_rdy, 39);
    chk("t1_first_aligned", first_al, 40);
    chk("t1_first_bits", first_bits, 10'b1010001110);
    chk("t1_cl_count", cl_cycs.size(), 2);
    if (cl_cycs.size() == 2) begin
      chk("t1_cl0", cl_cycs[0], 49);
      chk("t1_cl1", cl_cycs[1], 59);
    end
    chk("t1_rx_count", rx_q.size(), 6);

    // 2: back-to-back data
    send(10'h2A5, a1);
    send(10'h15A, a2);
    chk("t2_acc1", a1, 69);
    chk("t2_gap", a2 - a1, 10);
    idle(20);
    chk("t2_rx_count", rx_q.size(), 10);
    if (rx_q.size() >= 9) begin
      chk("t2_rx7", rx_q[7], 10'b1010100101);
      chk("t2_rx8", rx_q[8], 10'b0101011010);
    end

    // 3: valid raised mid-symbol
    for (int i = 0; i < 20 && (m_cyc % 10) != 4; i++) idle(1);
    raise = m_cyc;
    send(10'h3C3, t);
    chk("t3_wait", t - raise, 5);
    chk("t3_acc", t, 109);
    idle(12);

    // 5: saturating source
    for (int i = 0; i < 20; i++) begin
      cur = 10'h100 + 10'(i);
      send(cur, acc5[i]);
    end
    maxrun = 1; run = 1;
    for (int i = 1; i < 20; i++) begin
      if (acc5[i] - acc5[i-1] == 10) run++;
      else run = 1;
      if (run > maxrun) maxrun = run;
    end
    chk("t5_max_run", maxrun, PERIODIC ? 16 : 20);
    chk("t5_gap16", acc5[16] - acc5[15], PERIODIC ? 20 : 10);
    idle(12);

    // 6: COMMA sent as data
    send(COMMA_SYM, t);
    idle(12);
    hit = 0;
    foreach (det_q[i]) if (det_q[i] == t + 10) hit = 1;
    chk("t6_detect", hit, 1);
    hit = 0;
    foreach (cl_cycs[i]) if (cl_cycs[i] == t) hit = 1;
    chk("t6_no_comma_load", hit, 0);

    // 4: reset mid data symbol
    send(10'h2A5, t);
    repeat (5) @(posedge clk);
    #2;
    chk("t4_pre_ser", ser_out, 0);
    rst = 1'b1;
    #1;
    chk("t4_ser_out", ser_out, 1);
    chk("t4_sym_ready", sym_if.sym_ready, 0);
    chk("t4_sym_start", sym_start, 1);
    chk("t4_aligned", aligned, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(40);
    chk("t4_first_ready", first_rdy, 39);
    chk("t4_rx_count", rx_q.size(), 4);
    ncomma = 0;
    foreach (rx_q[i]) if (rx_q[i] == COMMA_SYM) ncomma++;
    chk("t4_burst", ncomma, 4);
    chk("t4_no_cl", cl_cycs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
